// File: rtl/fetch_unit_pkg.sv
// Shared fetch-unit types and constants: address/instruction widths, PC step and the buffered entry layout.
package fetch_unit_pkg;

    localparam int ADDR_W  = 8;
    localparam int INST_W  = 32;
    localparam int PC_STEP = 4;

    localparam logic [INST_W-1:0] NOP = 32'h00000013;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    // Instructions are word aligned, so the low two address bits are dropped.
    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry fetch buffer with push/pop/flush; pointers and count are reset, stored entries are not.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wr_entry,
    output logic [1:0]   count,
    output logic         full,
    output fetch_entry_t head_entry
);

    fetch_entry_t mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else if (flush) begin
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage carries data only; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wr_entry;
    end

    assign count      = count_q;
    assign full       = (count_q == 2'(DEPTH));
    assign head_entry = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC register, redirect handling and a two-entry buffer toward decode.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
    parameter int                DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              misalign
);

    logic [ADDR_W-1:0] pc_q;
    logic              misalign_p1;
    logic [1:0]        count;
    logic              full;
    logic              push;
    logic              pop;
    fetch_entry_t      wr_entry;
    fetch_entry_t      head_entry;

    assign inst_valid = (count != 2'd0);
    assign pop        = inst_valid && inst_ready;
    // A redirect wins over everything: no push on the flush edge.
    assign push       = fetch_en && !redirect_valid && (!full || pop);

    assign wr_entry.pc   = pc_q;
    assign wr_entry.inst = imem_data;

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_valid),
        .wr_entry  (wr_entry),
        .count     (count),
        .full      (full),
        .head_entry(head_entry)
    );

    // ---- stage p1: PC update and misalign flag ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            misalign_p1 <= 1'b0;
        end else begin
            misalign_p1 <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            if (redirect_valid) begin
                pc_q <= align_pc(redirect_pc);
            end else if (push) begin
                pc_q <= pc_q + ADDR_W'(PC_STEP);
            end
        end
    end

    assign imem_addr = pc_q;
    assign misalign  = misalign_p1;

    // Buffered data is not reset, so outputs are masked while the buffer is empty.
    assign inst_out = inst_valid ? head_entry.inst : '0;
    assign pc_out   = inst_valid ? head_entry.pc   : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus random checks of fetch_unit against a queue-based reference model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [7:0]  pc_out;
    logic        misalign;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC(8'h00),
        .DEPTH   (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_en      (fetch_en),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_out      (inst_out),
        .pc_out        (pc_out),
        .misalign      (misalign)
    );

    logic [31:0] imem [64];
    assign imem_data = imem[imem_addr[7:2]];

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference model: ordered list of {pc, inst}, next fetch address, misalign flag.
    logic [39:0] q [$];
    logic [7:0]  mpc;
    logic        mmis;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [39:0] h;
        h = (q.size() != 0) ? q[0] : 40'h0;
        check({tag, ".valid"},    32'(inst_valid), 32'(q.size() != 0));
        check({tag, ".inst_out"}, inst_out,        h[31:0]);
        check({tag, ".pc_out"},   32'(pc_out),     32'(h[39:32]));
        check({tag, ".imem_addr"},32'(imem_addr),  32'(mpc));
        check({tag, ".misalign"}, 32'(misalign),   32'(mmis));
    endtask

    task automatic model_reset();
        q.delete();
        mpc  = 8'h00;
        mmis = 1'b0;
    endtask

    // One clock edge of behaviour, computed from the inputs presented before the edge.
    task automatic model_step();
        int sz;
        bit do_pop;
        bit do_push;
        sz      = q.size();
        do_pop  = (sz != 0) && inst_ready;
        do_push = fetch_en && ((sz < 2) || do_pop);
        if (redirect_valid) begin
            q.delete();
            mpc  = 8'(int'(redirect_pc) - (int'(redirect_pc) % 4));
            mmis = (int'(redirect_pc) % 4) != 0;
        end else begin
            mmis = 1'b0;
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                q.push_back({mpc, imem[int'(mpc) / 4]});
                mpc = 8'((int'(mpc) + 4) % 256);
            end
        end
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // Assert reset between edges, check immediately, hold one edge, release at the falling edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("reset_async");
        @(posedge clk);
        #1;
        check_all("reset_hold");
        #4;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n          = 1'b1;
        fetch_en       = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        model_reset();
        for (int i = 0; i < 64; i++) imem[i] = $urandom;
        imem[0] = 32'h00A00093;
        imem[1] = 32'hFFB00113;
        imem[2] = 32'h002081B3;

        // Straight-line fetch from reset.
        do_reset();
        check("rst.inst_out", inst_out, 32'h0);
        fetch_en   = 1'b1;
        inst_ready = 1'b1;
        step("seq1");
        check("seq1.pc", 32'(pc_out), 32'h00);
        check("seq1.inst", inst_out, 32'h00A00093);
        step("seq2");
        check("seq2.pc", 32'(pc_out), 32'h04);
        check("seq2.inst", inst_out, 32'hFFB00113);
        step("seq3");
        check("seq3.pc", 32'(pc_out), 32'h08);
        check("seq3.inst", inst_out, 32'h002081B3);

        // Decode stall: buffer fills, PC holds.
        do_reset();
        fetch_en   = 1'b1;
        inst_ready = 1'b0;
        repeat (5) step("stall");
        check("stall.head_pc", 32'(pc_out), 32'h00);
        check("stall.pc_hold", 32'(imem_addr), 32'h08);
        inst_ready = 1'b1;
        step("unstall1");
        check("unstall1.pc", 32'(pc_out), 32'h04);
        step("unstall2");
        check("unstall2.pc", 32'(pc_out), 32'h08);

        // Misaligned redirect while full.
        inst_ready = 1'b0;
        step("fill1");
        step("fill2");
        redirect_valid = 1'b1;
        redirect_pc    = 8'h2A;
        step("redir2a");
        redirect_valid = 1'b0;
        check("redir2a.misalign", 32'(misalign), 32'h1);
        check("redir2a.pc", 32'(imem_addr), 32'h28);
        check("redir2a.flush", 32'(inst_valid), 32'h0);
        step("redir2a_fetch");
        check("redir2a_fetch.misalign", 32'(misalign), 32'h0);
        check("redir2a_fetch.head", 32'(pc_out), 32'h28);

        // PC wrap past 0xFC.
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 8'hF8;
        step("redirf8");
        redirect_valid = 1'b0;
        step("wrap1");
        step("wrap2");
        step("wrap3");
        check("wrap3.pc", 32'(pc_out), 32'h00);

        // Redirect coinciding with a pop.
        check("popredir.pre_valid", 32'(inst_valid), 32'h1);
        redirect_valid = 1'b1;
        redirect_pc    = 8'h10;
        step("popredir");
        redirect_valid = 1'b0;
        check("popredir.flush", 32'(inst_valid), 32'h0);
        step("popredir_next");
        check("popredir_next.pc", 32'(pc_out), 32'h10);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            fetch_en       = ($urandom_range(0, 3) != 0);
            inst_ready     = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = 8'($urandom_range(0, 255));
            step("rand");
        end

        // Asynchronous reset mid-cycle while holding two entries.
        redirect_valid = 1'b0;
        fetch_en       = 1'b1;
        inst_ready     = 1'b0;
        step("prefill1");
        step("prefill2");
        check("prefill.valid", 32'(inst_valid), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        check("async_rst.valid", 32'(inst_valid), 32'h0);
        #1;
        rst_n      = 1'b1;
        inst_ready = 1'b1;
        step("restart1");
        check("restart1.pc", 32'(pc_out), 32'h00);
        step("restart2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
